// File: rtl/medidor_periodo.sv
// rtl/medidor_periodo.sv - period measurer: enable ticks between rising edges of pulso, reported as period-1
// Valid/read handshake with saturation on overflow and a sticky lost-result flag.
module medidor_periodo #(
   parameter int modulo = 16,
   localparam int width_counter = $clog2(modulo)
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic                     enable,
   input  logic                     pulso,
   input  logic                     borrar,
   input  logic                     leer,
   output logic [width_counter-1:0] medida,
   output logic                     valida,
   output logic                     desborde,
   output logic                     perdido
);

   localparam int CW = $clog2(modulo + 1);
   localparam logic [CW-1:0] MOD_C = CW'(modulo);

   typedef enum logic {IDLE, MIDE} estado_t;

   estado_t                  state_q;
   logic                     pulso_q;
   logic [CW-1:0]            cnt_q;
   logic                     ovf_q;
   logic [width_counter-1:0] medida_q;
   logic                     valida_q;
   logic                     desborde_q;
   logic                     perdido_q;

   logic                     flanco;
   logic                     sat;
   logic [CW-1:0]            cnt_d;
   logic                     ovf_d;
   logic [CW-1:0]            per_m1;
   logic [width_counter-1:0] medida_d;
   logic                     nuevo;

   assign flanco = pulso & ~pulso_q;
   assign sat    = (cnt_q == MOD_C);
   // Period including the enable of the current cycle, so a closing edge counts its own tick.
   assign cnt_d  = sat ? cnt_q : cnt_q + CW'(enable);
   assign ovf_d  = ovf_q | (sat & enable);
   assign per_m1 = cnt_d - CW'(1);
   assign medida_d = ovf_d ? width_counter'(modulo - 1) : per_m1[width_counter-1:0];
   assign nuevo  = flanco & (state_q == MIDE) & (ovf_d | (cnt_d != '0));

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q    <= IDLE;
         pulso_q    <= 1'b0;
         cnt_q      <= '0;
         ovf_q      <= 1'b0;
         medida_q   <= '0;
         valida_q   <= 1'b0;
         desborde_q <= 1'b0;
         perdido_q  <= 1'b0;
      end else begin
         pulso_q <= pulso;
         if (borrar) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            ovf_q     <= 1'b0;
            valida_q  <= 1'b0;
            perdido_q <= 1'b0;
         end else begin
            if (flanco) begin
               state_q <= MIDE;
               cnt_q   <= '0;
               ovf_q   <= 1'b0;
            end else if (state_q == MIDE) begin
               cnt_q <= cnt_d;
               ovf_q <= ovf_d;
            end
            if (nuevo) begin
               medida_q   <= medida_d;
               desborde_q <= ovf_d;
               valida_q   <= 1'b1;
               perdido_q  <= valida_q & ~leer;
            end else if (leer && valida_q) begin
               valida_q  <= 1'b0;
               perdido_q <= 1'b0;
            end
         end
      end
   end

   assign medida   = medida_q;
   assign valida   = valida_q;
   assign desborde = desborde_q;
   assign perdido  = perdido_q;

endmodule
